// File: rtl/i2c_slave.sv
// Write-only I2C target that captures NCO configuration (enable/wave, duty cycle, frequency).
// Optional input glitch filter on SCL/SDA: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave #(
  parameter logic [6:0] ADDRESS = 7'b1101010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  output logic        enable,
  output logic [1:0]  wave,
  output logic [63:0] frequency,
  output logic [15:0] duty_cycle
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_s, sda_s;
  logic        scl_prev_q, sda_prev_q;
  logic        scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [3:0]  bit_cnt_q, byte_cnt_q;
  logic [7:0]  shbyte_q;
  logic [63:0] shreg_q;
  logic        byte_done_s, addr_match_s;
  logic        sda_oe_q, sda_oe_d, commit_s;
  logic        enable_q;
  logic [1:0]  wave_q;
  logic [63:0] frequency_q;
  logic [15:0] duty_cycle_q;

  // Two-flop synchronisers; idle bus level is high on both lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  // A filtered line follows its input only after three identical samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      if ((scl_sync_q[1] == scl_hist_q[0]) && (scl_hist_q[0] == scl_hist_q[1])) begin
        scl_filt_q <= scl_sync_q[1];
      end
      if ((sda_sync_q[1] == sda_hist_q[0]) && (sda_hist_q[0] == sda_hist_q[1])) begin
        sda_filt_q <= sda_sync_q[1];
      end
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // START/STOP need SCL high on both samples, so a simultaneous SCL/SDA change is a clock event.
  assign scl_rise_s   = scl_s & ~scl_prev_q;
  assign scl_fall_s   = ~scl_s & scl_prev_q;
  assign start_s      = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_s       = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_done_s  = (bit_cnt_q == 4'd8);
  assign addr_match_s = (shbyte_q[7:1] == ADDRESS) && (shbyte_q[0] == 1'b0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = ADDR;
    end else if (stop_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_fall_s && byte_done_s) begin
            state_d = addr_match_s ? ADDR_ACK : IGNORE;
          end else begin
            state_d = ADDR;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall_s) begin
            state_d = DATA;
          end else begin
            state_d = state_q;
          end
        end
        DATA: begin
          if (scl_fall_s && byte_done_s) begin
            state_d = (byte_cnt_q == 4'd8) ? IGNORE : DATA_ACK;
          end else begin
            state_d = DATA;
          end
        end
        IDLE, IGNORE: state_d = state_q;
        default:      state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sda_oe_d = (state_d == ADDR_ACK) || (state_d == DATA_ACK);
    commit_s = stop_s && (state_q == DATA);
  end

  // Bit/byte shifting; a completed data byte enters the payload on the SCL fall that ends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 4'd0;
      shbyte_q   <= 8'd0;
      shreg_q    <= 64'd0;
    end else if (start_s) begin
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 4'd0;
      shreg_q    <= 64'd0;
    end else if (((state_q == ADDR) || (state_q == DATA)) && scl_rise_s && !byte_done_s) begin
      shbyte_q  <= {shbyte_q[6:0], sda_s};
      bit_cnt_q <= bit_cnt_q + 4'd1;
    end else if (((state_q == ADDR) || (state_q == DATA)) && scl_fall_s && byte_done_s) begin
      bit_cnt_q <= 4'd0;
      if (state_q == DATA) begin
        shreg_q <= {shreg_q[55:0], shbyte_q};
        if (byte_cnt_q < 4'd8) begin
          byte_cnt_q <= byte_cnt_q + 4'd1;
        end
      end
    end
  end

  // Payload length picks the destination register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sda_oe_q     <= 1'b0;
      enable_q     <= 1'b0;
      wave_q       <= 2'd0;
      frequency_q  <= 64'd0;
      duty_cycle_q <= 16'd0;
    end else begin
      sda_oe_q <= sda_oe_d;
      if (commit_s) begin
        case (byte_cnt_q)
          4'd1: begin
            enable_q <= shreg_q[2];
            wave_q   <= shreg_q[1:0];
          end
          4'd2:    duty_cycle_q <= shreg_q[15:0];
          4'd8:    frequency_q  <= shreg_q;
          default: ;
        endcase
      end
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign enable     = enable_q;
  assign wave       = wave_q;
  assign frequency  = frequency_q;
  assign duty_cycle = duty_cycle_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: directed test-plan scenarios plus randomized
// transactions scored against a transaction-level model of the register map.
module tb_i2c_slave;
  localparam int HP = 8;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        scl        = 1'b1;
  logic        tb_sda_low = 1'b0;
  wire         sda;
  logic        enable;
  logic [1:0]  wave;
  logic [63:0] frequency;
  logic [15:0] duty_cycle;

  int checks      = 0;
  int errors      = 0;
  int dut_low_cnt = 0;

  logic [7:0]  tx_bytes [0:9];
  logic        ack_log  [0:10];
  logic        rel_all;
  logic        m_en;
  logic [1:0]  m_wave;
  logic [63:0] m_freq;
  logic [15:0] m_duty;

  always #5 clk = ~clk;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda        (sda),
    .enable     (enable),
    .wave       (wave),
    .frequency  (frequency),
    .duty_cycle (duty_cycle)
  );

  // Cycles in which the line is low while the bench is not pulling it.
  always @(posedge clk) begin
    if (!tb_sda_low && sda === 1'b0) dut_low_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0; scl = 1'b1; wait_cyc(HP);
    tb_sda_low = 1'b1; wait_cyc(HP);
    scl = 1'b0;
  endtask

  task automatic i2c_bit(input logic b);
    wait_cyc(2); tb_sda_low = ~b; wait_cyc(HP);
    scl = 1'b1; wait_cyc(HP);
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic rel);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    wait_cyc(2); tb_sda_low = 1'b0; wait_cyc(HP);
    scl = 1'b1; wait_cyc(HP / 2);
    ack = (sda === 1'b0);
    wait_cyc(HP / 2); scl = 1'b0;
    wait_cyc(8);
    rel = (sda === 1'b1);
  endtask

  task automatic i2c_stop();
    wait_cyc(2); tb_sda_low = 1'b1; wait_cyc(HP);
    scl = 1'b1; wait_cyc(HP);
    tb_sda_low = 1'b0; wait_cyc(HP);
  endtask

  // Reference model: a valid addressed write of length 1, 2 or 8 updates one register.
  task automatic model_apply(input logic [7:0] addr, input int n);
    if (addr == 8'hD4 && n <= 8) begin
      case (n)
        1: begin m_en = tx_bytes[0][2]; m_wave = tx_bytes[0][1:0]; end
        2: m_duty = {tx_bytes[0], tx_bytes[1]};
        8: begin
          m_freq = 64'd0;
          for (int i = 0; i < 8; i++) m_freq = (m_freq << 8) | {56'd0, tx_bytes[i]};
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic exp_ack(input logic [7:0] addr, input int slot);
    logic ok;
    ok = (addr == 8'hD4);
    return (slot == 0) ? ok : (ok && slot <= 8);
  endfunction

  task automatic run_xfer(input logic [7:0] addr, input int n);
    logic a, r;
    i2c_start();
    write_byte(addr, a, r);
    ack_log[0] = a; rel_all = r;
    for (int i = 0; i < n; i++) begin
      write_byte(tx_bytes[i], a, r);
      ack_log[i + 1] = a; rel_all = rel_all & r;
    end
    i2c_stop();
    model_apply(addr, n);
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_cyc(5); rst = 1'b0; wait_cyc(3);
    m_en = 1'b0; m_wave = 2'd0; m_freq = 64'd0; m_duty = 16'd0;
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", enable); end
    checks++; if (wave !== 2'd0) begin errors++; $display("FAIL reset_wave got %h exp 0", wave); end
    checks++; if (frequency !== 64'd0) begin errors++; $display("FAIL reset_freq got %h exp 0", frequency); end
    checks++; if (duty_cycle !== 16'd0) begin errors++; $display("FAIL reset_duty got %h exp 0", duty_cycle); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
  endtask

  task automatic test_frequency();
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h01; tx_bytes[2] = 8'hD4; tx_bytes[3] = 8'hC0;
    for (int i = 4; i < 8; i++) tx_bytes[i] = 8'h00;
    run_xfer(8'hD4, 8);
    for (int i = 0; i <= 8; i++) begin
      checks++;
      if (ack_log[i] !== 1'b1) begin errors++; $display("FAIL freq_ack[%0d] got %b exp 1", i, ack_log[i]); end
    end
    checks++; if (rel_all !== 1'b1) begin errors++; $display("FAIL freq_release got %b exp 1", rel_all); end
    checks++; if (frequency !== 64'h0001D4C000000000) begin errors++; $display("FAIL freq_value got %h exp 0001d4c000000000", frequency); end
    checks++;
    if ({enable, wave, duty_cycle} !== {m_en, m_wave, m_duty}) begin
      errors++; $display("FAIL freq_others got %b %h %h exp %b %h %h", enable, wave, duty_cycle, m_en, m_wave, m_duty);
    end
  endtask

  task automatic test_duty();
    tx_bytes[0] = 8'hFA; tx_bytes[1] = 8'hCE;
    run_xfer(8'hD4, 2);
    for (int i = 0; i <= 2; i++) begin
      checks++;
      if (ack_log[i] !== 1'b1) begin errors++; $display("FAIL duty_ack[%0d] got %b exp 1", i, ack_log[i]); end
    end
    checks++; if (duty_cycle !== 16'hFACE) begin errors++; $display("FAIL duty_value got %h exp face", duty_cycle); end
    checks++; if (frequency !== m_freq) begin errors++; $display("FAIL duty_freq_kept got %h exp %h", frequency, m_freq); end
  endtask

  task automatic test_ctrl();
    tx_bytes[0] = 8'h07;
    run_xfer(8'hD4, 1);
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL ctrl_enable got %b exp 1", enable); end
    checks++; if (wave !== 2'b11) begin errors++; $display("FAIL ctrl_wave got %b exp 11", wave); end
    checks++;
    if ({frequency, duty_cycle} !== {m_freq, m_duty}) begin
      errors++; $display("FAIL ctrl_others got %h %h exp %h %h", frequency, duty_cycle, m_freq, m_duty);
    end
  endtask

  task automatic test_wrong_addr();
    int low0;
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
    low0 = dut_low_cnt;
    run_xfer(8'hA0, 8);
    for (int i = 0; i <= 8; i++) begin
      checks++;
      if (ack_log[i] !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack[%0d] got %b exp 0", i, ack_log[i]); end
    end
    checks++; if (dut_low_cnt != low0) begin errors++; $display("FAIL wrong_addr_sda_driven got %0d cycles exp 0", dut_low_cnt - low0); end
    checks++;
    if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
      errors++; $display("FAIL wrong_addr_outputs got %b %h %h %h exp %b %h %h %h", enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
    end
  endtask

  task automatic test_lengths();
    int lens [0:1];
    lens[0] = 3; lens[1] = 9;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
      run_xfer(8'hD4, lens[k]);
      for (int i = 0; i <= lens[k]; i++) begin
        checks++;
        if (ack_log[i] !== exp_ack(8'hD4, i)) begin
          errors++; $display("FAIL len%0d_ack[%0d] got %b exp %b", lens[k], i, ack_log[i], exp_ack(8'hD4, i));
        end
      end
      checks++;
      if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
        errors++; $display("FAIL len%0d_outputs got %b %h %h %h exp %b %h %h %h", lens[k], enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic a, r;
    i2c_start();
    write_byte(8'hD4, a, r);
    write_byte(8'h11, a, r);
    write_byte(8'h22, a, r);
    write_byte(8'h33, a, r);
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
    tb_sda_low = 1'b0;
    rst = 1'b1; wait_cyc(3); rst = 1'b0; wait_cyc(3);
    m_en = 1'b0; m_wave = 2'd0; m_freq = 64'd0; m_duty = 16'd0;
    checks++;
    if ({enable, wave, frequency, duty_cycle} !== 83'd0) begin
      errors++; $display("FAIL midreset_outputs got %b %h %h %h exp all 0", enable, wave, frequency, duty_cycle);
    end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL midreset_sda got %b exp 1", sda); end
    tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34;
    run_xfer(8'hD4, 2);
    checks++; if (duty_cycle !== 16'h1234) begin errors++; $display("FAIL midreset_duty got %h exp 1234", duty_cycle); end
    checks++;
    if ({enable, wave, frequency} !== {m_en, m_wave, m_freq}) begin
      errors++; $display("FAIL midreset_others got %b %h %h exp %b %h %h", enable, wave, frequency, m_en, m_wave, m_freq);
    end
  endtask

  task automatic test_random();
    logic [7:0] addr;
    int n, sel;
    for (int t = 0; t < 8; t++) begin
      sel  = $urandom_range(0, 3);
      addr = (sel == 0) ? 8'($urandom_range(0, 255)) : ((sel == 1) ? 8'hD5 : 8'hD4);
      n    = (t < 3) ? ((t == 0) ? 1 : ((t == 1) ? 2 : 8)) : $urandom_range(0, 9);
      for (int i = 0; i < 10; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
      run_xfer(addr, n);
      for (int i = 0; i <= n; i++) begin
        checks++;
        if (ack_log[i] !== exp_ack(addr, i)) begin
          errors++; $display("FAIL rand%0d_ack[%0d] addr %h got %b exp %b", t, i, addr, ack_log[i], exp_ack(addr, i));
        end
      end
      checks++; if (rel_all !== 1'b1) begin errors++; $display("FAIL rand%0d_release got %b exp 1", t, rel_all); end
      checks++;
      if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
        errors++; $display("FAIL rand%0d_outputs addr %h len %0d got %b %h %h %h exp %b %h %h %h", t, addr, n, enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frequency();
    test_duty();
    test_ctrl();
    test_wrong_addr();
    test_lengths();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
